frame_readback: RTL and testbench

Reads a frame of IMG_WIDTH×IMG_HEIGHT pixels back out of the SRAM frame buffer after the test-pattern writer has filled it, and streams them downstream as 24-bit RGB with a valid/ready handshake. Sits directly downstream of the pattern generator on the shared SRAM port: the generator's `done` drives this block's `enable`. Read latency is absorbed by a small credit-controlled FIFO so downstream back-pressure never drops a pixel.

---
 rtl/frame_readback_pkg.sv | 15 +
 rtl/frame_readback_fifo.sv | 54 +++++
 rtl/frame_readback.sv | 153 +++++++++++++++
 tb/tb_frame_readback.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_readback_pkg.sv
// Shared widths and controller state encoding for the frame readback path.
package frame_readback_pkg;

    localparam int RGB_W   = 24;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rb_state_e;

endpackage

// File: rtl/frame_readback_fifo.sv
// Show-ahead circular FIFO: the head word is always on rdata_o, count_o tracks occupancy.
module readback_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 24,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;
    logic             full, do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push_i && (!full || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) rd_q <= ptr_inc(rd_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full && !pop_i));

endmodule

// File: rtl/frame_readback.sv
// Streams an IMG_WIDTH x IMG_HEIGHT frame out of SRAM with credit-limited reads.
// Optional FRAME_READBACK_CHECKSUM_EN adds frame_checksum_o (sum of popped pixels).
module frame_readback
    import frame_readback_pkg::*;
#(
    parameter int IMG_WIDTH    = 32,
    parameter int IMG_HEIGHT   = 32,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic [SRAM_AW-1:0] starting_address_i,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic               sram_rden_o,
    input  logic [SRAM_DW-1:0] sram_rdata_i,
    output logic [RGB_W-1:0]   pixel_data_o,
    output logic               pixel_valid_o,
    input  logic               pixel_ready_i,
    output logic               line_end_o,
    output logic               frame_end_o,
    output logic               busy_o,
`ifdef FRAME_READBACK_CHECKSUM_EN
    output logic [31:0]        frame_checksum_o,
`endif
    output logic               done_o
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int NW   = $clog2(NPIX + 1);
    localparam int HW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int VW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int OW   = 8;

    logic [1:0]              state_q, state_d;
    logic [SRAM_AW-1:0]      ptr_q, ptr_d;
    logic [NW-1:0]           issued_q, issued_d;
    logic [HW-1:0]           hcount_q, hcount_d;
    logic [VW-1:0]           vcount_q, vcount_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d, pipe_shift;
    logic [OW-1:0]           inflight, occupancy, count_next;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty, rden, push, pop, line_last;
    logic [7:0]              rdata_unused;

    assign rdata_unused = sram_rdata_i[31:24];

    readback_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RGB_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (sram_rdata_i[RGB_W-1:0]),
        .pop_i   (pop),
        .rdata_o (pixel_data_o),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + OW'(pipe_q[i]);
    end

    // Credits = FIFO_DEPTH - fifo_count - in_flight; issue only while one is left.
    assign occupancy  = OW'(fifo_count) + inflight;
    assign rden       = (state_q == S_READ) && (occupancy < OW'(FIFO_DEPTH));
    assign push       = pipe_q[READ_LATENCY-1];
    assign pop        = pixel_valid_o && pixel_ready_i;
    assign count_next = OW'(fifo_count) + OW'(push) - OW'(pop);
    assign pipe_shift = pipe_q << 1;
    assign pipe_d     = pipe_shift | READ_LATENCY'(rden);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        issued_d = issued_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pop) begin
            if (line_last) begin
                hcount_d = '0;
                vcount_d = (vcount_q == VW'(IMG_HEIGHT - 1)) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
        case (state_q)
            S_IDLE: if (enable_i) begin
                state_d  = S_READ;
                ptr_d    = starting_address_i;
                issued_d = '0;
                hcount_d = '0;
                vcount_d = '0;
            end
            S_READ: if (rden) begin
                ptr_d    = ptr_q + 1'b1;
                issued_d = issued_q + 1'b1;
                if (issued_q == NW'(NPIX - 1)) state_d = S_DRAIN;
            end
            // Leave on the edge that empties the pipeline so done follows the last pop directly.
            S_DRAIN: if (pipe_shift == '0 && count_next == '0) state_d = S_DONE;
            S_DONE:  if (!enable_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            issued_q <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            issued_q <= issued_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            pipe_q   <= pipe_d;
        end
    end

    assign line_last     = (hcount_q == HW'(IMG_WIDTH - 1));
    assign sram_rden_o   = rden;
    assign sram_addr_o   = rden ? ptr_q : '0;
    assign pixel_valid_o = !fifo_empty;
    assign line_end_o    = pixel_valid_o && line_last;
    assign frame_end_o   = line_end_o && (vcount_q == VW'(IMG_HEIGHT - 1));
    assign busy_o        = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done_o        = (state_q == S_DONE);

`ifdef FRAME_READBACK_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                csum_q <= '0;
        else if (state_q == S_IDLE && enable_i)     csum_q <= '0;
        else if (pop)                               csum_q <= csum_q + 32'(pixel_data_o);
    end

    assign frame_checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_frame_readback.sv
// Randomized bench for frame_readback: SRAM model, pixel-order scoreboard, credit and timing checks.
module tb_frame_readback;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [17:0] starting_address = '0;
    logic [17:0] sram_addr;
    logic        sram_rden;
    logic [31:0] sram_rdata;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready = 1'b1;
    logic        line_end, frame_end, busy, done;
`ifdef FRAME_READBACK_CHECKSUM_EN
    logic [31:0] frame_checksum;
`endif

    always #5 clk = ~clk;

    frame_readback dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .enable_i           (enable),
        .starting_address_i (starting_address),
        .sram_addr_o        (sram_addr),
        .sram_rden_o        (sram_rden),
        .sram_rdata_i       (sram_rdata),
        .pixel_data_o       (pixel_data),
        .pixel_valid_o      (pixel_valid),
        .pixel_ready_i      (pixel_ready),
        .line_end_o         (line_end),
        .frame_end_o        (frame_end),
        .busy_o             (busy),
`ifdef FRAME_READBACK_CHECKSUM_EN
        .frame_checksum_o   (frame_checksum),
`endif
        .done_o             (done)
    );

    // SRAM: word addressed at the rden cycle appears two cycles later.
    logic [31:0] mem [0:262143];
    logic [17:0] a1, a2;
    logic        v1, v2;
    always @(posedge clk) begin
        a1 <= sram_addr; v1 <= sram_rden;
        a2 <= a1;        v2 <= v1;
    end
    assign sram_rdata = v2 ? mem[a2] : 32'hDEAD_BEEF;

    int tests = 0, failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard state
    logic        active = 1'b0;
    logic        idx_pattern = 1'b0;
    logic        rand_ready = 1'b0;
    logic [17:0] base;
    int          pop_idx, issue_idx, cyc, first_rden, first_valid, done_cyc;
    logic [31:0] sum;

    always @(posedge clk) begin
        #1;
        pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (active) begin
            logic [23:0] exp_px;
            cyc++;
            chk("done", {31'b0, done}, {31'b0, pop_idx == N});
            chk("busy", {31'b0, busy}, {31'b0, pop_idx != N});
            if (done && done_cyc == 0) done_cyc = cyc;
            if (sram_rden) begin
                if (first_rden == 0) first_rden = cyc;
                chk("read_count", {31'b0, issue_idx < N}, 32'd1);
                chk("sram_addr", {14'b0, sram_addr}, {14'b0, base + 18'(issue_idx)});
                chk("outstanding_le_4", {31'b0, (issue_idx + 1 - pop_idx) <= 4}, 32'd1);
                issue_idx++;
            end
            if (pixel_valid) begin
                if (first_valid == 0) first_valid = cyc;
                chk("pixel_count", {31'b0, pop_idx < N}, 32'd1);
                exp_px = mem[base + 18'(pop_idx)][23:0];
                chk("pixel_data", {8'b0, pixel_data}, {8'b0, exp_px});
                if (idx_pattern) chk("pixel_index", {8'b0, pixel_data}, pop_idx);
                chk("line_end", {31'b0, line_end}, {31'b0, (pop_idx % 32) == 31});
                chk("frame_end", {31'b0, frame_end}, {31'b0, pop_idx == N - 1});
                if (pixel_ready) begin
                    sum = sum + 32'(exp_px);
                    pop_idx++;
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_addr"},  {14'b0, sram_addr}, 32'd0);
        chk({tag, "_rden"},  {31'b0, sram_rden}, 32'd0);
        chk({tag, "_pixel"}, {8'b0, pixel_data}, 32'd0);
        chk({tag, "_valid"}, {31'b0, pixel_valid}, 32'd0);
        chk({tag, "_lend"},  {31'b0, line_end}, 32'd0);
        chk({tag, "_fend"},  {31'b0, frame_end}, 32'd0);
        chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
        chk({tag, "_done"},  {31'b0, done}, 32'd0);
    endtask

    task automatic start_frame(input logic [17:0] st, input bit rr);
        starting_address = st;
        rand_ready = rr;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        base = st; pop_idx = 0; issue_idx = 0; cyc = 0;
        first_rden = 0; first_valid = 0; done_cyc = 0; sum = '0;
        active = 1'b1;
    endtask

    task automatic run_frame(input logic [17:0] st, input bit rr, input bit toggle_en);
        int t = 0;
        start_frame(st, rr);
        while (pop_idx < N && t < 20000) begin
            @(posedge clk); #1; t++;
            enable = (toggle_en && pop_idx < 512) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk("frame_timeout", {31'b0, pop_idx == N}, 32'd1);
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("first_rden_cycle", first_rden, 32'd1);
        chk("first_valid_cycle", first_valid, 32'd4);
        if (!rr) chk("done_cycle", done_cyc, 32'd1028);
        chk("read_total", issue_idx, N);
`ifdef FRAME_READBACK_CHECKSUM_EN
        chk("checksum_model", frame_checksum, sum);
`endif
        enable = 1'b0;
        @(posedge clk); #1;
        active = 1'b0;
        @(negedge clk);
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_rden", {31'b0, sram_rden}, 32'd0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 262144; i++) mem[i] = $urandom;
        for (int k = 0; k < N; k++) mem[18'h00100 + k] = {8'hA5, 24'(k)};

        #12;
        check_quiet("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        // Index pattern, ready always high: order, framing and exact latency.
        idx_pattern = 1'b1;
        run_frame(18'h00100, 1'b0, 1'b0);
        // Same frame again with random back-pressure and enable noise while busy.
        run_frame(18'h00100, 1'b1, 1'b1);
        idx_pattern = 1'b0;

        // Addresses wrap past 0x3FFFF.
        run_frame(18'h3FFF0, 1'b1, 1'b0);

        // Asynchronous reset around pixel 500, then a clean restart.
        start_frame(18'h00100, 1'b0);
        t = 0;
        while (pop_idx < 500 && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        chk("reach_500", {31'b0, pop_idx >= 500}, 32'd1);
        active = 1'b0;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check_quiet("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idx_pattern = 1'b1;
        run_frame(18'h00100, 1'b0, 1'b0);
        idx_pattern = 1'b0;

`ifdef FRAME_READBACK_CHECKSUM_EN
        for (int k = 0; k < N; k++) mem[18'h00100 + k] = {8'($urandom), 24'hC0C0C0};
        run_frame(18'h00100, 1'b1, 1'b0);
        chk("checksum_c0", frame_checksum, 32'h0303_0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
